day_trading_stream: RTL

Streaming, parametrised successor to the single-shot day-trading classifier. Accepts one price per handshake into a DEPTH-deep sliding window and classifies the window trend into five classes. Tracks the held position internally, not via an input ownership bit, and emits one registered action code per accepted price once the window is full. Sits between the price-feed interface and the order-generation logic, with valid/ready handshakes on both sides.

---
 rtl/day_trading_stream.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/day_trading_stream.sv
// day_trading_stream: streaming price-window trend classifier with an
// internally tracked position and one registered action per accepted price
// once the window is full.
// Optional feature: define DAY_TRADING_STATS_EN to enable the trades_out
// counter (otherwise trades_out is tied to zero).
module day_trading_stream #(
  parameter int PRICE_W   = 8,
  parameter int DEPTH     = 4,
  parameter int STRONG_TH = 8,
  parameter int WEAK_TH   = 3,
  parameter int POS_MAX   = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             price_valid,
  output logic                             price_ready,
  input  logic [PRICE_W-1:0]               price_in,
  input  logic                             flush,
  output logic                             action_valid,
  input  logic                             action_ready,
  output logic [3:0]                       action_out,
  output logic [$clog2(POS_MAX+1)-1:0]     position_out,
  output logic [15:0]                      trades_out
);

  localparam int POS_W = $clog2(POS_MAX + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = POS_W + 3;

  localparam logic [PRICE_W:0]   STRONG_M = (PRICE_W + 1)'(STRONG_TH);
  localparam logic [PRICE_W:0]   WEAK_M   = (PRICE_W + 1)'(WEAK_TH);
  localparam logic [POS_W-1:0]   POS_LIM  = POS_W'(POS_MAX);
  localparam logic [SUM_W-1:0]   SUM_LIM  = SUM_W'(POS_MAX);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEPTH - 1);

  localparam logic [3:0] ACT_SELL_ALL   = 4'd1;
  localparam logic [3:0] ACT_STAY_OUT   = 4'd2;
  localparam logic [3:0] ACT_BUY_MORE   = 4'd3;
  localparam logic [3:0] ACT_BUY_LOT    = 4'd4;
  localparam logic [3:0] ACT_SELL_SOME  = 4'd5;
  localparam logic [3:0] ACT_BUY_LITTLE = 4'd7;
  localparam logic [3:0] ACT_HOLD       = 4'd8;

  typedef enum logic [1:0] {FILL, ACCEPT, DECIDE, OUT} state_e;

  state_e               state_q, state_d;
  logic                 armed_q, armed_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PRICE_W-1:0]   win_q [DEPTH];
  logic [PRICE_W-1:0]   win_d [DEPTH];
  logic [3:0]           action_q, action_d;
  logic [POS_W-1:0]     pos_q, pos_d;

  logic                 price_fire;
  logic signed [PRICE_W:0] trend;
  logic [PRICE_W:0]     mag;
  logic                 is_strong, is_weak, is_down, own;
  logic                 buy_en;
  logic [2:0]           buy_amt;
  logic [3:0]           buy_code;
  logic [SUM_W-1:0]     buy_sum;
  logic [3:0]           dec_action;
  logic [POS_W-1:0]     dec_pos;

  assign price_fire = price_valid & price_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FILL;
    else      state_q <= state_d;
  end

  // Next-state logic; flush overrides every state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = FILL;
    end else begin
      unique case (state_q)
        FILL:    if (price_fire && count_q == CNT_LAST) state_d = DECIDE;
        ACCEPT:  if (price_fire) state_d = DECIDE;
        DECIDE:  state_d = OUT;
        OUT:     if (action_ready) state_d = ACCEPT;
        default: state_d = FILL;
      endcase
    end
  end

  // Handshake outputs; armed_q keeps ready low until the first edge after reset
  always_comb begin
    price_ready  = armed_q & ~flush & ((state_q == FILL) | (state_q == ACCEPT));
    action_valid = (state_q == OUT);
    action_out   = action_q;
    position_out = pos_q;
  end

  // Trend classification and action/position decision from the action table
  always_comb begin
    trend     = $signed({1'b0, win_q[0]}) - $signed({1'b0, win_q[DEPTH-1]});
    mag       = trend[PRICE_W] ? $unsigned(-trend) : $unsigned(trend);
    is_down   = trend[PRICE_W];
    is_strong = (mag >= STRONG_M);
    is_weak   = !is_strong && (mag >= WEAK_M);
    own       = (pos_q != '0);
    buy_en    = 1'b0;
    buy_amt   = '0;
    buy_code  = ACT_HOLD;
    dec_action = ACT_HOLD;
    dec_pos    = pos_q;
    if (is_strong && !is_down) begin
      if (own) begin
        dec_action = ACT_SELL_ALL;
        dec_pos    = '0;
      end else begin
        dec_action = ACT_STAY_OUT;
      end
    end else if (is_weak && !is_down) begin
      if (own) begin
        dec_action = ACT_SELL_SOME;
        dec_pos    = pos_q - 1'b1;
      end else begin
        dec_action = ACT_STAY_OUT;
      end
    end else if (is_strong) begin
      buy_en   = 1'b1;
      buy_amt  = own ? 3'd2 : 3'd4;
      buy_code = own ? ACT_BUY_MORE : ACT_BUY_LOT;
    end else if (!own) begin
      // flat or weak down with nothing held
      buy_en   = 1'b1;
      buy_amt  = 3'd1;
      buy_code = ACT_BUY_LITTLE;
    end
    buy_sum = SUM_W'(pos_q) + SUM_W'(buy_amt);
    if (buy_en) begin
      if (pos_q == POS_LIM) begin
        dec_action = ACT_HOLD;
      end else begin
        dec_action = buy_code;
        dec_pos    = (buy_sum > SUM_LIM) ? POS_LIM : buy_sum[POS_W-1:0];
      end
    end
  end

  // Window shift, fill count and registered decision
  always_comb begin
    armed_d  = 1'b1;
    count_d  = count_q;
    win_d    = win_q;
    action_d = action_q;
    pos_d    = pos_q;
    if (flush) begin
      count_d = '0;
    end else begin
      if (price_fire) begin
        for (int unsigned i = DEPTH - 1; i > 0; i--) win_d[i] = win_q[i-1];
        win_d[0] = price_in;
        if (count_q != CNT_FULL) count_d = count_q + 1'b1;
      end
      if (state_q == DECIDE) begin
        action_d = dec_action;
        pos_d    = dec_pos;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q  <= 1'b0;
      count_q  <= '0;
      win_q    <= '{default: '0};
      action_q <= '0;
      pos_q    <= '0;
    end else begin
      armed_q  <= armed_d;
      count_q  <= count_d;
      win_q    <= win_d;
      action_q <= action_d;
      pos_q    <= pos_d;
    end
  end

`ifdef DAY_TRADING_STATS_EN
  logic [15:0] trades_q, trades_d;

  // Count decisions that actually move the position, saturating
  always_comb begin
    trades_d = trades_q;
    if (!flush && state_q == DECIDE && dec_pos != pos_q && trades_q != 16'hFFFF)
      trades_d = trades_q + 16'd1;
  end

  // Trade counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) trades_q <= '0;
    else      trades_q <= trades_d;
  end

  assign trades_out = trades_q;
`else
  assign trades_out = '0;
`endif

endmodule
